// File: rtl/icache_set_assoc.sv
// N-way set-associative instruction cache with PLRU replacement, refill handshake and one-cycle flush.
// Optional hit/miss counters are compiled in with ICACHE_PERF_COUNTERS_EN.
module icache_set_assoc #(
    parameter int ADDR_WIDTH  = 17,
    parameter int INST_WIDTH  = 32,
    parameter int LINE_WIDTH  = 2,
    parameter int INDEX_WIDTH = 5,
    parameter int WAYS        = 2,
    parameter int TAG_WIDTH   = ADDR_WIDTH - INDEX_WIDTH - LINE_WIDTH
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                rdy,
    input  logic [ADDR_WIDTH-1:0]               fetch_addr,
    output logic                                fetch_hit,
    output logic [INST_WIDTH-1:0]               fetch_data,
    input  logic                                flush,
    output logic                                mem_req_valid,
    output logic [ADDR_WIDTH-1:0]               mem_req_addr,
    input  logic                                mem_resp_valid,
    input  logic [(INST_WIDTH<<LINE_WIDTH)-1:0] mem_resp_data
`ifdef ICACHE_PERF_COUNTERS_EN
    ,
    output logic [31:0]                         perf_hits,
    output logic [31:0]                         perf_misses
`endif
);

    localparam int SETS      = 1 << INDEX_WIDTH;
    localparam int LINE_BITS = INST_WIDTH << LINE_WIDTH;
    localparam int WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int PLRU_W    = (WAYS == 4) ? 3 : 1;

    typedef enum logic {S_IDLE, S_REFILL} state_t;

    state_t                r_state;
    logic                  r_req_valid;
    logic                  r_drop;
    logic [WAY_W-1:0]      r_way;
    logic [ADDR_WIDTH-1:0] r_req_addr;
    logic [WAYS-1:0]       r_valid [SETS];
    logic [PLRU_W-1:0]     r_plru  [SETS];
    logic [TAG_WIDTH-1:0]  r_tag   [WAYS][SETS];
    logic [LINE_BITS-1:0]  r_data  [WAYS][SETS];

    logic [INDEX_WIDTH-1:0] w_set;
    logic [INDEX_WIDTH-1:0] w_fill_set;
    logic [TAG_WIDTH-1:0]   w_tag;
    logic [TAG_WIDTH-1:0]   w_fill_tag;
    logic [LINE_WIDTH-1:0]  w_word;
    logic [WAYS-1:0]        w_match;
    logic                   w_hit_any;
    logic [WAY_W-1:0]       w_hit_way;
    logic [WAY_W-1:0]       w_victim;
    logic [WAY_W-1:0]       w_plru_victim;
    logic [PLRU_W-1:0]      w_plru_hit_nxt;
    logic [PLRU_W-1:0]      w_plru_fill_nxt;
    logic [LINE_BITS-1:0]   w_line;
    logic                   w_install;

    assign w_set      = fetch_addr[LINE_WIDTH +: INDEX_WIDTH];
    assign w_tag      = fetch_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
    assign w_word     = fetch_addr[LINE_WIDTH-1:0];
    assign w_fill_set = r_req_addr[LINE_WIDTH +: INDEX_WIDTH];
    assign w_fill_tag = r_req_addr[ADDR_WIDTH-1 -: TAG_WIDTH];

    always_comb begin
        w_match   = '0;
        w_hit_way = '0;
        for (int w = 0; w < WAYS; w++)
            w_match[w] = r_valid[w_set][w] && (r_tag[w][w_set] == w_tag);
        for (int w = WAYS - 1; w >= 0; w--)
            if (w_match[w]) w_hit_way = WAY_W'(w);
    end

    assign w_hit_any  = |w_match;
    assign w_line     = r_data[w_hit_way][w_set];
    assign fetch_data = w_line[int'(w_word)*INST_WIDTH +: INST_WIDTH];
    assign fetch_hit  = !rst && rdy && (r_state == S_IDLE) && !flush && w_hit_any;

    // Invalid ways take priority over the replacement policy, lowest index first.
    always_comb begin
        w_victim = w_plru_victim;
        for (int w = WAYS - 1; w >= 0; w--)
            if (!r_valid[w_set][w]) w_victim = WAY_W'(w);
    end

    // Tree bits: [0] root (0 -> ways 0/1, 1 -> ways 2/3), [1] within 0/1, [2] within 2/3.
    generate
        if (WAYS == 4) begin : g_tree
            logic [2:0] w_ph;
            logic [2:0] w_pf;
            always_comb begin
                w_ph    = r_plru[w_set];
                w_ph[0] = ~w_hit_way[1];
                if (w_hit_way[1]) w_ph[2] = ~w_hit_way[0];
                else              w_ph[1] = ~w_hit_way[0];
                w_pf    = r_plru[w_fill_set];
                w_pf[0] = ~r_way[1];
                if (r_way[1]) w_pf[2] = ~r_way[0];
                else          w_pf[1] = ~r_way[0];
            end
            assign w_plru_hit_nxt  = w_ph;
            assign w_plru_fill_nxt = w_pf;
            assign w_plru_victim   = r_plru[w_set][0] ? {1'b1, r_plru[w_set][2]}
                                                      : {1'b0, r_plru[w_set][1]};
        end else if (WAYS == 2) begin : g_lru
            assign w_plru_hit_nxt  = w_hit_way;
            assign w_plru_fill_nxt = r_way;
            assign w_plru_victim   = ~r_plru[w_set];
        end else begin : g_direct
            assign w_plru_hit_nxt  = 1'b0;
            assign w_plru_fill_nxt = 1'b0;
            assign w_plru_victim   = '0;
        end
    endgenerate

    assign w_install = !rst && rdy && (r_state == S_REFILL) && mem_resp_valid && !flush && !r_drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_req_valid <= 1'b0;
            r_req_addr  <= '0;
            r_drop      <= 1'b0;
            r_way       <= '0;
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_plru[s]  <= '0;
            end
        end else if (rdy) begin
            case (r_state)
                S_IDLE: begin
                    if (flush) begin
                        for (int s = 0; s < SETS; s++) r_valid[s] <= '0;
                    end else if (w_hit_any) begin
                        r_plru[w_set] <= w_plru_hit_nxt;
                    end else begin
                        r_req_addr  <= {fetch_addr[ADDR_WIDTH-1:LINE_WIDTH], {LINE_WIDTH{1'b0}}};
                        r_way       <= w_victim;
                        r_req_valid <= 1'b1;
                        r_state     <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (flush) begin
                        for (int s = 0; s < SETS; s++) r_valid[s] <= '0;
                    end
                    if (mem_resp_valid) begin
                        if (w_install) begin
                            r_valid[w_fill_set][r_way] <= 1'b1;
                            r_plru[w_fill_set]         <= w_plru_fill_nxt;
                        end
                        r_drop      <= 1'b0;
                        r_req_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end else if (flush) begin
                        r_drop <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_install) begin
            r_tag[r_way][w_fill_set]  <= w_fill_tag;
            r_data[r_way][w_fill_set] <= mem_resp_data;
        end
    end

    assign mem_req_valid = r_req_valid;
    assign mem_req_addr  = r_req_addr;

`ifdef ICACHE_PERF_COUNTERS_EN
    logic [31:0] r_perf_hits;
    logic [31:0] r_perf_misses;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_hits   <= '0;
            r_perf_misses <= '0;
        end else if (rdy && (r_state == S_IDLE)) begin
            if (fetch_hit)
                r_perf_hits <= r_perf_hits + 32'd1;
            if (!flush && !w_hit_any)
                r_perf_misses <= r_perf_misses + 32'd1;
        end
    end

    assign perf_hits   = r_perf_hits;
    assign perf_misses = r_perf_misses;
`endif

endmodule

// File: tb/tb_icache_set_assoc.sv
// Directed bench for icache_set_assoc: one 2-way and one 4-way instance, selected per scenario.
module tb_icache_set_assoc;

    logic         clk = 1'b0;
    logic         rst;
    logic         rdy;
    logic         flush;
    logic [16:0]  fetch_addr;
    logic         mem_resp_valid;
    logic [127:0] mem_resp_data;
    int           sel;

    logic         hit2, hit4, rv2, rv4;
    logic [31:0]  data2, data4;
    logic [16:0]  ra2, ra4;
    logic         rsp2, rsp4;

    logic         hit, rv;
    logic [31:0]  data;
    logic [16:0]  ra;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Only the selected instance sees responses; the other idles harmlessly in REFILL.
    assign rsp2 = mem_resp_valid && (sel == 2);
    assign rsp4 = mem_resp_valid && (sel == 4);

    always_comb begin
        if (sel == 4) begin
            hit = hit4; data = data4; rv = rv4; ra = ra4;
        end else begin
            hit = hit2; data = data2; rv = rv2; ra = ra2;
        end
    end

`ifdef ICACHE_PERF_COUNTERS_EN
    logic [31:0] ph2, pm2, ph4, pm4;
`endif

    icache_set_assoc #(.WAYS(2)) dut2 (
        .clk(clk), .rst(rst), .rdy(rdy), .fetch_addr(fetch_addr),
        .fetch_hit(hit2), .fetch_data(data2), .flush(flush),
        .mem_req_valid(rv2), .mem_req_addr(ra2),
        .mem_resp_valid(rsp2), .mem_resp_data(mem_resp_data)
`ifdef ICACHE_PERF_COUNTERS_EN
        , .perf_hits(ph2), .perf_misses(pm2)
`endif
    );

    icache_set_assoc #(.WAYS(4)) dut4 (
        .clk(clk), .rst(rst), .rdy(rdy), .fetch_addr(fetch_addr),
        .fetch_hit(hit4), .fetch_data(data4), .flush(flush),
        .mem_req_valid(rv4), .mem_req_addr(ra4),
        .mem_resp_valid(rsp4), .mem_resp_data(mem_resp_data)
`ifdef ICACHE_PERF_COUNTERS_EN
        , .perf_hits(ph4), .perf_misses(pm4)
`endif
    );

    function automatic logic [127:0] mk_line(input logic [31:0] base);
        return {base + 32'd3, base + 32'd2, base + 32'd1, base};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; rdy = 1'b1; flush = 1'b0; mem_resp_valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // Miss on a, then answer the refill request with line for one cycle.
    task automatic fill(input logic [16:0] a, input logic [127:0] line);
        fetch_addr = a;
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_data  = line;
        tick();
        mem_resp_valid = 1'b0;
    endtask

    task automatic test_reset();
        sel = 2; fetch_addr = 17'h0; mem_resp_data = '0;
        rst = 1'b1; rdy = 1'b1; flush = 1'b0; mem_resp_valid = 1'b0;
        tick(); tick();
        checks++; if (rv !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %0b want 0", rv); end
        checks++; if (ra !== 17'h0) begin errors++; $display("FAIL reset_req_addr: got %h want 00000", ra); end
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL reset_hit: got %0b want 0", hit); end
        rst = 1'b0;
        #1;
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL reset_empty_hit: got %0b want 0", hit); end
    endtask

    task automatic test_cold_miss();
        sel = 2; do_reset();
        fetch_addr = 17'h00005;
        #1;
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL cold_first_hit: got %0b want 0", hit); end
        tick();
        checks++; if (rv !== 1'b1) begin errors++; $display("FAIL cold_req_valid: got %0b want 1", rv); end
        checks++; if (ra !== 17'h00004) begin errors++; $display("FAIL cold_req_addr: got %h want 00004", ra); end
        mem_resp_valid = 1'b1;
        mem_resp_data  = {32'h44, 32'h33, 32'h22, 32'h11};
        #1;
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL cold_no_bypass: got %0b want 0", hit); end
        tick();
        mem_resp_valid = 1'b0;
        #1;
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL cold_hit: got %0b want 1", hit); end
        checks++; if (data !== 32'h22) begin errors++; $display("FAIL cold_data: got %h want 00000022", data); end
        checks++; if (rv !== 1'b0) begin errors++; $display("FAIL cold_req_drop: got %0b want 0", rv); end
        fetch_addr = 17'h00007;
        #1;
        checks++; if (data !== 32'h44) begin errors++; $display("FAIL cold_word3: got %h want 00000044", data); end
    endtask

    task automatic test_conflict_2way();
        sel = 2; do_reset();
        fill(17'h00000, mk_line(32'h100));
        fill(17'h00080, mk_line(32'h200));
        fetch_addr = 17'h00000;
        #1;
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL conf_refetch: got %0b want 1", hit); end
        tick();
        fill(17'h00100, mk_line(32'h300));
        fetch_addr = 17'h00000;
        #1;
        checks++; if (hit !== 1'b1 || data !== 32'h100) begin errors++; $display("FAIL conf_keep_0: hit %0b data %h want 1 00000100", hit, data); end
        fetch_addr = 17'h00102;
        #1;
        checks++; if (hit !== 1'b1 || data !== 32'h302) begin errors++; $display("FAIL conf_new_100: hit %0b data %h want 1 00000302", hit, data); end
        fetch_addr = 17'h00080;
        #1;
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL conf_evict_80: got %0b want 0", hit); end
    endtask

    task automatic test_plru_4way();
        sel = 4; do_reset();
        fill(17'h0000C, mk_line(32'hA0));
        fill(17'h0008C, mk_line(32'hB0));
        fill(17'h0010C, mk_line(32'hC0));
        fill(17'h0018C, mk_line(32'hD0));
        fetch_addr = 17'h0000C; tick();
        fetch_addr = 17'h0010C; tick();
        fill(17'h0020C, mk_line(32'hE0));
        fetch_addr = 17'h0008C;
        #1;
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL plru_evict_B: got %0b want 0", hit); end
        fetch_addr = 17'h0000D;
        #1;
        checks++; if (hit !== 1'b1 || data !== 32'hA1) begin errors++; $display("FAIL plru_keep_A: hit %0b data %h want 1 000000a1", hit, data); end
        fetch_addr = 17'h0010E;
        #1;
        checks++; if (hit !== 1'b1 || data !== 32'hC2) begin errors++; $display("FAIL plru_keep_C: hit %0b data %h want 1 000000c2", hit, data); end
        fetch_addr = 17'h0018F;
        #1;
        checks++; if (hit !== 1'b1 || data !== 32'hD3) begin errors++; $display("FAIL plru_keep_D: hit %0b data %h want 1 000000d3", hit, data); end
        fetch_addr = 17'h0020D;
        #1;
        checks++; if (hit !== 1'b1 || data !== 32'hE1) begin errors++; $display("FAIL plru_new_E: hit %0b data %h want 1 000000e1", hit, data); end
    endtask

    task automatic test_flush();
        sel = 2; do_reset();
        fetch_addr = 17'h00010;
        tick();
        checks++; if (rv !== 1'b1 || ra !== 17'h00010) begin errors++; $display("FAIL flush_req: valid %0b addr %h want 1 00010", rv, ra); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        checks++; if (rv !== 1'b1) begin errors++; $display("FAIL flush_req_held: got %0b want 1", rv); end
        mem_resp_valid = 1'b1; mem_resp_data = mk_line(32'h510);
        tick();
        mem_resp_valid = 1'b0;
        #1;
        checks++; if (rv !== 1'b0 || hit !== 1'b0) begin errors++; $display("FAIL flush_dropped: valid %0b hit %0b want 0 0", rv, hit); end
        tick();
        checks++; if (rv !== 1'b1 || ra !== 17'h00010) begin errors++; $display("FAIL flush_rereq: valid %0b addr %h want 1 00010", rv, ra); end
        mem_resp_valid = 1'b1; flush = 1'b1;
        tick();
        mem_resp_valid = 1'b0; flush = 1'b0;
        #1;
        checks++; if (hit !== 1'b0 || rv !== 1'b0) begin errors++; $display("FAIL flush_with_resp: hit %0b valid %0b want 0 0", hit, rv); end
        tick();
        mem_resp_valid = 1'b1;
        tick();
        mem_resp_valid = 1'b0;
        #1;
        checks++; if (hit !== 1'b1 || data !== 32'h510) begin errors++; $display("FAIL flush_refill_ok: hit %0b data %h want 1 00000510", hit, data); end
        flush = 1'b1;
        #1;
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL flush_idle_hit: got %0b want 0", hit); end
        tick();
        flush = 1'b0;
        #1;
        checks++; if (hit !== 1'b0 || rv !== 1'b0) begin errors++; $display("FAIL flush_idle_after: hit %0b valid %0b want 0 0", hit, rv); end
    endtask

    task automatic test_rdy_stall();
        sel = 2; do_reset();
        fetch_addr = 17'h00020;
        rdy = 1'b0;
        tick();
        checks++; if (rv !== 1'b0) begin errors++; $display("FAIL stall_idle_frozen: got %0b want 0", rv); end
        rdy = 1'b1;
        tick();
        mem_resp_valid = 1'b1; mem_resp_data = mk_line(32'h620);
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (rv !== 1'b1) begin errors++; $display("FAIL stall_req_held: cycle %0d got %0b want 1", i, rv); end
        end
        rdy = 1'b1; mem_resp_valid = 1'b0;
        #1;
        checks++; if (hit !== 1'b0 || rv !== 1'b1) begin errors++; $display("FAIL stall_no_install: hit %0b valid %0b want 0 1", hit, rv); end
        mem_resp_valid = 1'b1;
        tick();
        mem_resp_valid = 1'b0;
        #1;
        checks++; if (hit !== 1'b1 || data !== 32'h620) begin errors++; $display("FAIL stall_install: hit %0b data %h want 1 00000620", hit, data); end
    endtask

    task automatic test_reset_mid_refill();
        sel = 2; do_reset();
        fill(17'h00040, mk_line(32'h740));
        fetch_addr = 17'h00040;
        rst = 1'b1;
        #1;
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL rst_gates_hit: got %0b want 0", hit); end
        tick();
        rst = 1'b0;
        fetch_addr = 17'h00044;
        tick();
        checks++; if (rv !== 1'b1) begin errors++; $display("FAIL rst_mid_req: got %0b want 1", rv); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        fetch_addr = 17'h00040;
        #1;
        checks++; if (rv !== 1'b0 || ra !== 17'h0) begin errors++; $display("FAIL rst_mid_abandon: valid %0b addr %h want 0 00000", rv, ra); end
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL rst_invalidated: got %0b want 0", hit); end
    endtask

`ifdef ICACHE_PERF_COUNTERS_EN
    task automatic test_counters();
        sel = 2; do_reset();
        fill(17'h00000, mk_line(32'h800));
        fill(17'h00004, mk_line(32'h810));
        fill(17'h00008, mk_line(32'h820));
        fetch_addr = 17'h00000;
        for (int i = 0; i < 10; i++) tick();
        checks++; if (pm2 !== 32'd3) begin errors++; $display("FAIL perf_misses: got %0d want 3", pm2); end
        checks++; if (ph2 !== 32'd10) begin errors++; $display("FAIL perf_hits: got %0d want 10", ph2); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++; if (pm2 !== 32'd0 || ph2 !== 32'd0) begin errors++; $display("FAIL perf_reset: misses %0d hits %0d want 0 0", pm2, ph2); end
    endtask
`endif

    initial begin
        test_reset();
        test_cold_miss();
        test_conflict_2way();
        test_plru_4way();
        test_flush();
        test_rdy_stall();
        test_reset_mid_refill();
`ifdef ICACHE_PERF_COUNTERS_EN
        test_counters();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
